// File: rtl/sort_pkg.sv
// Shared types and constants for the frame sorter (fixed 8-element frames).
package sort_pkg;
   localparam int DEPTH       = 8;
   localparam int SORT_CYCLES = 28;
   localparam int CNT_W       = 3;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SORT,
      OUT
   } state_t;
endpackage

// File: rtl/sort_rr_arb.sv
// Two-requester round-robin arbiter; the priority pointer moves past the
// winner whenever the grant-update strobe is pulsed.
module sort_rr_arb (
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt,
   output logic       gnt_idx
);
   logic prio_q, prio_d;

   always_comb begin
      gnt_idx = prio_q;
      if (!req[prio_q]) gnt_idx = ~prio_q;
      gnt    = req[gnt_idx] ? (2'b01 << gnt_idx) : 2'b00;
      prio_d = prio_q;
      if (upd && |req) prio_d = ~gnt_idx;
   end

   always_ff @(posedge clk) begin
      if (!resetn) prio_q <= 1'b0;
      else         prio_q <= prio_d;
   end
endmodule

// File: rtl/sort_sched.sv
// Two-requester frame sorter: load up to 8 elements, bubble-sort one
// compare-exchange per cycle, present largest-first. SORT_EARLY_EXIT_EN ends
// SORT after the first pass without a swap.
module sort_sched
   import sort_pkg::*;
#(
   parameter int BITWIDTH = 3
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [1:0]                req_valid,
   input  logic [2*BITWIDTH-1:0]     req_din,
   input  logic [1:0]                req_last,
   output logic [1:0]                req_ready,
   output logic [DEPTH*BITWIDTH-1:0] dout,
   output logic                      dout_tag,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic                      busy
);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);
   localparam logic [4:0]       LAST_CYC  = 5'(SORT_CYCLES - 1);

   state_t                         state_q, state_d;
   logic                           tag_q, tag_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [CNT_W-1:0]               pass_q, pass_d;
   logic [CNT_W-1:0]               idx_q, idx_d, idx_nx;
   logic [4:0]                     cyc_q, cyc_d;
   logic [DEPTH-1:0][BITWIDTH-1:0] mem_q, mem_d;
   logic [BITWIDTH-1:0]            din_sel, cur, nxt;
   logic                           do_swap, pass_end, sort_done;
   logic [1:0]                     gnt;
   logic                           gnt_idx, arb_upd;
`ifdef SORT_EARLY_EXIT_EN
   logic                           swp_q, swp_d;
`endif

   sort_rr_arb u_arb (
      .clk     (clk),
      .resetn  (resetn),
      .req     (req_valid),
      .upd     (arb_upd),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign din_sel  = tag_q ? req_din[2*BITWIDTH-1 -: BITWIDTH] : req_din[BITWIDTH-1:0];
   assign idx_nx   = idx_q + 3'd1;
   assign cur      = mem_q[idx_q];
   assign nxt      = mem_q[idx_nx];
   assign do_swap  = cur > nxt;
   assign pass_end = (idx_nx == pass_q);

   always_comb begin
      state_d   = state_q;
      tag_d     = tag_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      idx_d     = idx_q;
      cyc_d     = cyc_q;
      mem_d     = mem_q;
      req_ready = 2'b00;
      arb_upd   = 1'b0;
      sort_done = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      swp_d     = swp_q;
`endif
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               arb_upd = 1'b1;
               tag_d   = gnt_idx;
               mem_d   = '0;
               cnt_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            req_ready[tag_q] = 1'b1;
            if (req_valid[tag_q]) begin
               mem_d[cnt_q] = din_sel;
               cnt_d        = cnt_q + 3'd1;
               if (cnt_q == LAST_SLOT || req_last[tag_q]) begin
                  state_d = SORT;
                  pass_d  = LAST_SLOT;
                  idx_d   = '0;
                  cyc_d   = '0;
`ifdef SORT_EARLY_EXIT_EN
                  swp_d   = 1'b0;
`endif
               end
            end
         end
         SORT: begin
            if (do_swap) begin
               mem_d[idx_q]  = nxt;
               mem_d[idx_nx] = cur;
            end
            cyc_d     = cyc_q + 5'd1;
            sort_done = (cyc_q == LAST_CYC);
            if (pass_end) begin
               idx_d  = '0;
               pass_d = pass_q - 3'd1;
            end else begin
               idx_d  = idx_nx;
            end
`ifdef SORT_EARLY_EXIT_EN
            // A pass with no exchange proves the frame is already ordered.
            swp_d = swp_q | do_swap;
            if (pass_end) begin
               if (!(swp_q | do_swap)) sort_done = 1'b1;
               swp_d = 1'b0;
            end
`endif
            if (sort_done) state_d = OUT;
         end
         OUT: begin
            if (dout_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         tag_q   <= 1'b0;
         cnt_q   <= '0;
         pass_q  <= '0;
         idx_q   <= '0;
         cyc_q   <= '0;
         mem_q   <= '0;
`ifdef SORT_EARLY_EXIT_EN
         swp_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         idx_q   <= idx_d;
         cyc_q   <= cyc_d;
         mem_q   <= mem_d;
`ifdef SORT_EARLY_EXIT_EN
         swp_q   <= swp_d;
`endif
      end
   end

   assign busy       = (state_q != IDLE);
   assign dout_valid = (state_q == OUT);
   assign dout_tag   = dout_valid & tag_q;

   // Storage ends ascending, so the largest element sits in the top slot.
   for (genvar k = 0; k < DEPTH; k++) begin : g_dout
      assign dout[k*BITWIDTH +: BITWIDTH] = dout_valid ? mem_q[DEPTH-1-k] : '0;
   end
endmodule

// File: tb/tb_sort_sched.sv
// Self-checking bench for sort_sched: directed frames plus random frames
// against a reference built from the sorting and arbitration rules.
module tb_sort_sched;
   localparam int BW = 3;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_last = '0;
   logic [2*BW-1:0] req_din = '0;
   logic            dout_ready = 1'b0;
   wire  [1:0]      req_ready;
   wire  [8*BW-1:0] dout;
   wire             dout_tag, dout_valid, busy;

   int n_assert = 0;
   int n_fail   = 0;
   int prio_m   = 0;

   always #5 clk = ~clk;

   sort_sched #(.BITWIDTH(BW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_din    (req_din),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .dout       (dout),
      .dout_tag   (dout_tag),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // k-th largest of the frame (zero padded) lands in slice k.
   function automatic logic [8*BW-1:0] model_dout(input logic [BW-1:0] a[8]);
      logic [BW-1:0]   b[8];
      logic [8*BW-1:0] r;
      int              m;
      b = a;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         m = 0;
         for (int j = 1; j < 8; j++) if (b[j] > b[m]) m = j;
         r[k*BW +: BW] = b[m];
         b[m] = '0;
      end
      return r;
   endfunction

   // Cycles spent sorting: 7+6+...+1 unless passes stop early.
   function automatic int model_lat(input logic [BW-1:0] a[8]);
      logic [BW-1:0] b[8];
      logic [BW-1:0] t;
      int            cyc;
`ifdef SORT_EARLY_EXIT_EN
      bit            sw;
`endif
      b   = a;
      cyc = 0;
      for (int i = 7; i >= 1; i--) begin
`ifdef SORT_EARLY_EXIT_EN
         sw = 1'b0;
`endif
         for (int j = 0; j < i; j++) begin
            cyc++;
            if (b[j] > b[j+1]) begin
               t = b[j]; b[j] = b[j+1]; b[j+1] = t;
`ifdef SORT_EARLY_EXIT_EN
               sw = 1'b1;
`endif
            end
         end
`ifdef SORT_EARLY_EXIT_EN
         if (!sw) break;
`endif
      end
      return cyc;
   endfunction

   // Requester r streams n elements; the other one (if both) holds noise.
   task automatic send(input int r, input int n, input logic [BW-1:0] v[8],
                       input bit both, input bit last8);
      int t;
      for (int k = 0; k < n; k++) begin
         req_valid[r]         = 1'b1;
         req_din[r*BW +: BW]  = v[k];
         req_last[r]          = (k == n-1) && (n < 8 || last8);
         if (both) begin
            req_valid[1-r]          = 1'b1;
            req_din[(1-r)*BW +: BW] = BW'($urandom);
            req_last[1-r]           = 1'($urandom);
         end
         #1;
         t = 0;
         while (req_ready[r] !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         chk("ready_grant", {30'd0, req_ready}, 32'(1 << r));
         @(posedge clk); #1;
      end
      req_valid = '0;
      req_last  = '0;
   endtask

   task automatic drain(input int tag, input logic [BW-1:0] a[8], input int hold);
      int              lat;
      logic [8*BW-1:0] e;
      e   = model_dout(a);
      lat = 0;
      while (dout_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, model_lat(a));
      chk("dout", dout, e);
      chk("dout_tag", dout_tag, tag);
      chk("dout_valid", dout_valid, 1);
      if (hold > 0) begin
         dout_ready = 1'b0;
         repeat (hold) @(posedge clk);
         #1;
         chk("dout_hold", {busy, dout_valid, dout}, {2'b11, e});
      end
      dout_ready = 1'b1;
      @(posedge clk); #1;
      dout_ready = 1'b0;
      chk("idle_after_out", {busy, dout_valid, dout_tag, dout}, 0);
   endtask

   initial begin
      logic [BW-1:0] a[8];
      int            r, n, main;
      bit            both;

      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {req_ready, busy, dout_valid, dout_tag, dout}, 0);
      resetn = 1'b1;

      // Full frame from requester 0, consumer stalls 10 cycles.
      a = '{3, 7, 0, 5, 1, 6, 2, 4};
      send(0, 8, a, 1'b0, 1'b1);
      prio_m = 1;
      drain(0, a, 10);

      // Already sorted input, sole requester 1, 8th element without last.
      a = '{0, 1, 2, 3, 4, 5, 6, 7};
      send(1, 8, a, 1'b0, 1'b0);
      prio_m = 0;
      drain(1, a, 0);

      // Both requesting after reset: 0 first, then 1 (short frame 5,2).
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      a = '{1, 6, 3, 6, 0, 0, 0, 0};
      send(0, 4, a, 1'b1, 1'b1);
      drain(0, a, 2);
      a = '{5, 2, 0, 0, 0, 0, 0, 0};
      send(1, 2, a, 1'b1, 1'b1);
      drain(1, a, 0);

      // Reset in the middle of SORT aborts the frame and restores priority.
      a = '{7, 7, 1, 0, 4, 2, 6, 3};
      send(1, 8, a, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      chk("busy_in_sort", {busy, dout_valid}, 2'b10);
      resetn = 1'b0;
      @(posedge clk); #1;
      chk("abort_outputs", {req_ready, busy, dout_valid, dout_tag, dout}, 0);
      resetn = 1'b1;
      a = '{2, 5, 5, 1, 7, 0, 0, 0};
      send(0, 5, a, 1'b1, 1'b1);
      prio_m = 1;
      drain(0, a, 1);

      for (int f = 0; f < 12; f++) begin
         r    = $urandom_range(0, 1);
         both = 1'($urandom_range(0, 1));
         n    = $urandom_range(1, 8);
         for (int k = 0; k < 8; k++) a[k] = (k < n) ? BW'($urandom) : '0;
         main = both ? prio_m : r;
         send(main, n, a, both, 1'($urandom));
         prio_m = 1 - main;
         drain(main, a, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/sort_sched.md
SORT_SCHED -- requirements
Module: sort_sched

Interface
REQ-001 SHALL have parameter BITWIDTH, default 3, the element width in bits; frame depth is fixed at 8 elements (package constant).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  2  per-requester element valid.
REQ-005 SHALL have port req_din  input  2*BITWIDTH  element data; requester r occupies slice [r*BITWIDTH +: BITWIDTH].
REQ-006 SHALL have port req_last  input  2  per-requester last element of frame.
REQ-007 SHALL have port req_ready  output  2  per-requester element accept.
REQ-008 SHALL have port dout  output  8*BITWIDTH  sorted frame; slice k = k-th largest element, so slice 0 is the largest.
REQ-009 SHALL have port dout_tag  output  1  index of the requester that owns dout.
REQ-010 SHALL have port dout_valid  output  1  sorted frame available.
REQ-011 SHALL have port dout_ready  input  1  consumer accepts dout.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SORT, OUT.
REQ-014 IDLE: if any req_valid is high, SHALL grant one requester round-robin, clear all 8 storage slots, and go to LOAD next cycle; no element is accepted in IDLE.
REQ-015 Round-robin: requester 0 has priority after reset; after each granted frame, priority passes to the other requester; a sole requester is always granted.
REQ-016 LOAD: req_ready SHALL be high only for the granted requester; an element is accepted when its valid and ready are both high, is written to slot cnt, and cnt increments.
REQ-017 LOAD SHALL end, going to SORT, on acceptance of the 8th element or of any element with req_last high; unfilled slots remain 0.
REQ-018 SORT: SHALL perform exactly one compare-exchange per cycle in bubble order (pass i = 7 down to 1, j = 0..i-1; swap if slot j > slot j+1, unsigned), 28 cycles total, then go to OUT.
REQ-019 OUT: dout_valid SHALL be high and dout/dout_tag SHALL hold stable until dout_ready is sampled high; SHALL then go to IDLE.
REQ-020 SHALL drive dout to 0 whenever dout_valid is low.
REQ-021 The ungranted requester SHALL see req_ready low for the whole frame, and its inputs SHALL be ignored.
REQ-022 Equal elements SHALL NOT be swapped.

Reset
REQ-023 While resetn is low at a clock edge: state IDLE, storage, cnt and dout cleared to 0, dout_valid/dout_tag/busy/req_ready 0, round-robin priority to requester 0.
REQ-024 Reset asserted mid-LOAD, mid-SORT or mid-OUT SHALL abort the frame; no partial result is ever presented.

Configuration
REQ-025 Macro SORT_EARLY_EXIT_EN defined: SORT SHALL track swaps per pass and go to OUT at the end of the first pass in which no swap occurred (minimum 7 cycles).
REQ-026 Macro SORT_EARLY_EXIT_EN undefined: SORT latency SHALL be exactly 28 cycles, independent of the data.

Structure
REQ-027 Package sort_pkg SHALL hold the state enum typedef, DEPTH=8, and the SORT cycle count constant 28.
REQ-028 The round-robin grant SHALL be a sub-module sort_rr_arb (2 requesters, priority pointer, grant-update strobe).

Verification
REQ-029 Requester 0 sends 3,7,0,5,1,6,2,4 (last on the 8th element) -> 28 edges after the final accept, dout=0x053977, dout_tag=0, dout_valid=1.
REQ-030 Both req_valid high in IDLE after reset -> requester 0 is granted first; after its frame completes, with both still valid, requester 1 is granted.
REQ-031 Requester 1 sends 5,2 with last on 2 -> dout slices 0..7 = 5,2,0,0,0,0,0,0; dout_tag=1.
REQ-032 dout_ready held low 10 cycles in OUT -> dout/dout_valid stable; then IDLE one cycle after dout_ready goes high.
REQ-033 resetn pulsed low at SORT cycle 10 -> all outputs 0 next cycle, then a new frame sorts correctly with requester 0 priority.
REQ-034 With SORT_EARLY_EXIT_EN, input 0,1,2,3,4,5,6,7 -> dout_valid 7 edges after the final accept; without the macro, 28.
